fp_cmp_pipe: RTL

- Parametrised, pipelined IEEE 754 floating-point compare / min / max unit with valid/ready handshake on both sides.
- Successor to the combinational compare unit:
  - adds configurable latency, backpressure and min/max operations;
  - adds a live invalid (nanx) flag, with quiet vs signaling compare modes;
  - adds a tag pass-through so the issue logic can match results to requests.
- Sits between the FP register-read stage and the FP result bus.

---
 rtl/fp_cmp_pipe.sv | 106 ++++++++++
 1 files changed

// File: rtl/fp_cmp_pipe.sv
// fp_cmp_pipe: LAT-stage FP compare/min/max; op/a/b/tag in via i_valid/i_ready, o/res/nanx/tag_o out via o_valid/o_ready
module fp_cmp_pipe #(
  parameter int FPWID = 64,
  parameter int LAT   = 2,
  parameter int TAGW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [1:0]       op,
  input  logic [FPWID-1:0] a,
  input  logic [FPWID-1:0] b,
  input  logic [TAGW-1:0]  tag,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [4:0]       o,
  output logic [FPWID-1:0] res,
  output logic             nanx,
  output logic [TAGW-1:0]  tag_o
);
  localparam int EMSB = FPWID == 16 ? 4 : FPWID == 32 ? 7 : FPWID == 64 ? 10 : 14;
  localparam int FMSB = FPWID - EMSB - 3;
  localparam logic [FPWID-1:0] QNAN = {1'b0, {(EMSB+1){1'b1}}, 1'b1, {FMSB{1'b0}}};
  typedef struct packed {
    logic             v;
    logic [1:0]       op;
    logic [FPWID-1:0] a;
    logic [FPWID-1:0] b;
    logic             an;
    logic             bn;
    logic             asn;
    logic             bsn;
    logic             bz;
    logic [TAGW-1:0]  tag;
  } dec_t;
  typedef struct packed {
    logic [4:0]       o;
    logic [FPWID-1:0] res;
    logic             nanx;
  } out_t;
  function automatic logic is_nan(logic [FPWID-1:0] x);
    return &x[FPWID-2:FMSB+1] & |x[FMSB:0];
  endfunction
  dec_t dec_in, last_d;
  out_t out_d, out_q;
  logic ov_q, en;
  logic [TAGW-1:0] tag_q;
  logic sa, sb, un, mlt, mgt, sel, eq, lt;
  assign en      = !ov_q | o_ready;
  assign i_ready = en;
  assign o_valid = ov_q;
  assign o       = out_q.o;
  assign res     = out_q.res;
  assign nanx    = out_q.nanx;
  assign tag_o   = tag_q;
  always_comb begin
    dec_in.v   = i_valid;
    dec_in.op  = op;
    dec_in.a   = a;
    dec_in.b   = b;
    dec_in.an  = is_nan(a);
    dec_in.bn  = is_nan(b);
    dec_in.asn = is_nan(a) & !a[FMSB];
    dec_in.bsn = is_nan(b) & !b[FMSB];
    dec_in.bz  = ~|{a[FPWID-2:0], b[FPWID-2:0]};
    dec_in.tag = tag;
  end
  if (LAT == 1) begin : g_one
    assign last_d = dec_in;
  end else begin : g_pipe
    localparam int SHW = (LAT-1) * $bits(dec_t);
    dec_t [LAT-2:0] sh_q;
    always_ff @(posedge clk)
      if (rst) sh_q <= '0;
      else if (en) sh_q <= SHW'({sh_q, dec_in});
    assign last_d = sh_q[LAT-2];
  end
  assign sa  = last_d.a[FPWID-1];
  assign sb  = last_d.b[FPWID-1];
  assign un  = last_d.an | last_d.bn;
  assign mlt = last_d.a[FPWID-2:0] < last_d.b[FPWID-2:0];
  assign mgt = last_d.a[FPWID-2:0] > last_d.b[FPWID-2:0];
  assign sel = sa != sb ? sa : sa ? mgt : mlt;
  assign eq  = !un & (last_d.bz | last_d.a == last_d.b);
  assign lt  = !un & !last_d.bz & sel;
  always_comb begin
    out_d.o    = {un, mlt, lt | eq, lt, eq};
    out_d.nanx = last_d.op == 2'd1 ? un : last_d.asn | last_d.bsn;
    out_d.res  = !last_d.op[1] ? '0 :
                 last_d.an & last_d.bn ? QNAN :
                 last_d.an ? last_d.b :
                 last_d.bn ? last_d.a :
                 (sel ^ last_d.op[0]) ? last_d.a : last_d.b;
  end
  always_ff @(posedge clk)
    if (rst) begin
      ov_q  <= 1'b0;
      out_q <= '0;
      tag_q <= '0;
    end else if (en) begin
      ov_q  <= last_d.v;
      out_q <= out_d;
      tag_q <= last_d.tag;
    end
endmodule
